// File: rtl/packet_space_releaser.sv
// ---------------------------------------------------------------------------
// packet_space_releaser
//
// Read-side companion of the packet planner. Completed packet lengths arrive
// as MVB words in planner order. Each length is rounded up to the planner
// alignment and the freed bytes are accumulated. They are handed back to the
// planner in batches by advancing the space read pointer.
//
// Ports
//   clk             clock
//   rst_n           asynchronous reset, active low
//   rx_len_i        ITEMS packed lengths, item 0 in the LSBs
//   rx_vld_i        per-item valid
//   rx_src_rdy_i    word valid
//   rx_dst_rdy_o    ready; low in reset, high afterwards (no backpressure)
//   flush_i         force release of a non-empty accumulator
//   space_wr_ptr_i  planner write pointer, bounds what may be released
//   space_rd_ptr_o  released read pointer
//   rd_ptr_vld_o    one-cycle pulse when space_rd_ptr_o takes a new value
//   err_o           sticky: a release asked for more bytes than were in use
//
// Pipeline: word accepted in cycle N -> aligned lengths in N+1 -> accumulator
// in N+2 -> earliest pointer change visible in N+3.
// ---------------------------------------------------------------------------
module packet_space_releaser #(
    parameter int ITEMS      = 4,
    parameter int LEN_WIDTH  = 15,
    parameter int SPACE_SIZE = 65536,
    parameter int ALIGN      = 8,
    parameter int THRESHOLD  = 512,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ITEMS*LEN_WIDTH-1:0]      rx_len_i,
    input  logic [ITEMS-1:0]                rx_vld_i,
    input  logic                            rx_src_rdy_i,
    output logic                            rx_dst_rdy_o,
    input  logic                            flush_i,
    input  logic [$clog2(SPACE_SIZE)-1:0]   space_wr_ptr_i,
    output logic [$clog2(SPACE_SIZE)-1:0]   space_rd_ptr_o,
    output logic                            rd_ptr_vld_o,
    output logic                            err_o
);

    localparam int PTR_WIDTH = $clog2(SPACE_SIZE);
    localparam int ACC_W     = PTR_WIDTH + 1;
    localparam int AL_W      = LEN_WIDTH + 1;
    localparam int SUM_W     = AL_W + $clog2(ITEMS);
    localparam int WIDE_W    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int TMR_W     = $clog2(TIMEOUT) + 1;

    localparam logic [AL_W-1:0]  ALIGN_M1 = AL_W'(ALIGN - 1);
    localparam logic [ACC_W-1:0] THRESH   = ACC_W'(THRESHOLD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    logic                  rdy_q;
    logic [AL_W-1:0]       aligned_d [ITEMS];
    logic [AL_W-1:0]       aligned_q [ITEMS];
    logic [ACC_W-1:0]      acc_d, acc_q;
    logic [TMR_W-1:0]      timer_d, timer_q;
    state_t                state_d, state_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_d, rd_ptr_q;
    logic                  vld_d, vld_q;
    logic                  err_d, err_q;

    logic                  xfer;
    logic [WIDE_W-1:0]     word_sum;
    logic [WIDE_W-1:0]     acc_sum;
    logic [PTR_WIDTH-1:0]  used;
    logic [PTR_WIDTH-1:0]  rel;
    logic                  commit;
    logic                  over;

    assign xfer           = rx_src_rdy_i & rdy_q;
    assign rx_dst_rdy_o   = rdy_q;
    assign space_rd_ptr_o = rd_ptr_q;
    assign rd_ptr_vld_o   = vld_q;
    assign err_o          = err_q;

    // Stage 1: round every valid length up to the alignment; invalid items
    // and idle cycles contribute nothing.
    always_comb begin
        for (int i = 0; i < ITEMS; i++) begin
            aligned_d[i] = '0;
            if (xfer && rx_vld_i[i]) begin
                aligned_d[i] = ({1'b0, rx_len_i[i*LEN_WIDTH +: LEN_WIDTH]} + ALIGN_M1) & ~ALIGN_M1;
            end
        end
    end

    // Stage 2 input: total freed bytes of the word held in stage 1.
    always_comb begin
        word_sum = '0;
        for (int i = 0; i < ITEMS; i++) begin
            word_sum = word_sum + WIDE_W'(aligned_q[i]);
        end
    end

    // Release decision and pointer arithmetic. The accumulator restarts from
    // the incoming word on a commit cycle so those bytes are kept. Only the
    // bytes actually in use between read and write pointer are released; an
    // excess request flags the sticky error.
    always_comb begin
        commit   = (acc_q != '0) &&
                   ((acc_q >= THRESH) ||
                    ((state_q == ACCUM) && (timer_q == TMR_LAST)) ||
                    flush_i);
        used     = space_wr_ptr_i - rd_ptr_q;
        over     = acc_q > {1'b0, used};
        rel      = over ? used : acc_q[PTR_WIDTH-1:0];
        acc_sum  = (commit ? '0 : WIDE_W'(acc_q)) + word_sum;
        acc_d    = acc_sum[ACC_W-1:0];

        rd_ptr_d = rd_ptr_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        if (commit) begin
            rd_ptr_d = rd_ptr_q + rel;
            vld_d    = (rel != '0);
            if (over) begin
                err_d = 1'b1;
            end
        end
    end

    // FSM next state: ACCUM whenever bytes are pending. The timer counts the
    // age of the current batch and restarts after every commit.
    always_comb begin
        state_d = (acc_d != '0) ? ACCUM : IDLE;
        timer_d = '0;
        if ((state_q == ACCUM) && (state_d == ACCUM) && !commit) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Pipeline, accumulator, FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            acc_q    <= '0;
            timer_q  <= '0;
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < ITEMS; i++) begin
                aligned_q[i] <= '0;
            end
        end else begin
            rdy_q    <= 1'b1;
            acc_q    <= acc_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            for (int i = 0; i < ITEMS; i++) begin
                aligned_q[i] <= aligned_d[i];
            end
        end
    end

    // The accumulator must never exceed its width; this guards the
    // parameter relation between threshold, lengths and space size on the
    // traffic actually seen.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (acc_sum[WIDE_W-1:ACC_W] == '0);
        end
    end

endmodule
